axis_pps_timer: RTL and testbench
=================================

Name: axis_pps_timer

Overview:
- Timestamps a 1PPS input against aclk. Each second it emits one AXI-Stream word over a handshake: {flags, seconds, cycles}.
- Generalises the plain PPS period counter with:
  - parametrised counter, seconds and tdata widths
  - tready backpressure with drop accounting
  - runtime glitch rejection (minimum period)
  - holdover: synthetic ticks when PPS is lost
- Sits between the GPS/PPS pin and the DMA/PS-side FIFO in the timing subsystem.

Parameters:
- AXIS_TDATA_WIDTH, 64, output word width; must be >= CNTR_WIDTH+SEC_WIDTH+2.
- CNTR_WIDTH, 30, width of the per-second cycle counter.
- SEC_WIDTH, 32, width of the seconds counter.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- pps_data  in  1  asynchronous PPS input
- cfg_min  in  CNTR_WIDTH  minimum accepted period in cycles; 0 disables glitch rejection
- cfg_timeout  in  CNTR_WIDTH  holdover period in cycles; 0 disables synthetic ticks
- m_axis_tdata  out  AXIS_TDATA_WIDTH  {zero pad, dropped, synthetic, seconds[SEC_WIDTH], cycles[CNTR_WIDTH]}
- m_axis_tvalid  out  1  word valid
- m_axis_tready  in  1  downstream ready
- sts_locked  out  1  armed, and the last tick was a real PPS edge

Behaviour:
- Reset: aresetn is synchronous, active-low; clock is aclk. While low, every register clears; m_axis_tvalid=0, m_axis_tdata=0, sts_locked=0, armed=0, cnt=0, seconds=0, dropped=0.
- Reset mid-operation aborts any pending word, which is not emitted. The block re-arms only on the next edge.
- Input conditioning: 3-stage shift register on pps_data. A rising edge is detected when stage[1]=1 and stage[2]=0.
- Cycle counter (cnt):
  - increments every cycle and saturates at all-ones (no wrap)
  - loads 0 in any cycle where a tick occurs
  - period value N = cnt+1, saturating at all-ones
- Arming: while unarmed, the first detected edge sets armed, clears cnt and seconds, and emits no word.
- Real tick: armed, edge detected, and (cfg_min==0 or N>=cfg_min).
- Rejected edge: armed, edge detected, and N<cfg_min. It is ignored completely; cnt keeps counting.
- Synthetic tick: armed, cfg_timeout!=0, no real tick this cycle, and N==cfg_timeout.
- Simultaneous events:
  - a real edge and the timeout in the same cycle produce one real tick, synthetic=0
  - a rejected edge plus the timeout produce a synthetic tick
- On any tick:
  - seconds <= seconds+1, wrapping modulo 2^SEC_WIDTH
  - word = {dropped, synthetic, seconds+1, N}
  - sts_locked <= ~synthetic
- Output register: a single entry, fully registered.
  - tvalid rises on the aclk edge after the detect cycle, i.e. the 3rd rising edge after pps_data is first sampled high.
  - tvalid and tdata stay stable until tvalid&tready.
  - tready may be high before tvalid.
- Full: a tick while tvalid=1 and tready=0 drops the new word. dropped is set sticky; seconds and cnt still advance.
- A tick in the same cycle as tvalid&tready loads the new word with no bubble.
- dropped clears when a word carrying dropped=1 is loaded into the output register.
- cfg_min and cfg_timeout are sampled every cycle; changes take effect immediately.
- Upper tdata bits above CNTR_WIDTH+SEC_WIDTH+2 are 0.

Decomposition:
- Package axis_pps_timer_pkg holds:
  - field offsets: CYC_LSB=0, SEC_LSB=CNTR_WIDTH, SYN_BIT=CNTR_WIDTH+SEC_WIDTH, DROP_BIT=SYN_BIT+1
  - a width-check function for the AXIS_TDATA_WIDTH constraint
- Sub-module pps_edge_sync: 3-stage synchroniser plus rising-edge pulse. Reused by other PPS consumers.

Test Plan:
- PPS period 10 cycles, tready=1, defaults -> first edge emits nothing; then words cycles=10, seconds=1,2,3, flags=0, sts_locked=1; tvalid pulses 1 cycle each.
- cfg_min=8, extra 1-cycle pulse 4 cycles after a tick within a 10-cycle train -> glitch ignored; next word cycles=10.
- cfg_timeout=12, PPS stops after 2 ticks -> synthetic words every 12 cycles, cycles=12, synthetic=1, sts_locked=0. PPS resumes -> real word, synthetic=0, sts_locked=1.
- tready=0 across 3 ticks (period 10), then tready=1 -> first word held stable with seconds=1; ticks 2 and 3 dropped; next word seconds=4 with dropped=1; the following word has dropped=0.
- SEC_WIDTH=4, 17 ticks -> seconds sequence wraps 15 -> 0 -> 1.
- aresetn low for 1 cycle while tvalid=1 (tready=0) -> tvalid=0 next cycle; no word until two edges after release.

Source files
------------

// File: rtl/axis_pps_timer_pkg.sv
// Shared definitions for the PPS timestamp block.
// Holds the tdata field offsets, the tdata width check and the arming state type.
package axis_pps_timer_pkg;

  // Cycle count always occupies the low bits of tdata.
  localparam int unsigned CYC_LSB = 0;

  // Seconds field sits directly above the cycle count.
  function automatic int unsigned sec_lsb(input int unsigned cntr_w);
    return cntr_w;
  endfunction

  // Synthetic flag sits directly above the seconds field.
  function automatic int unsigned syn_bit(input int unsigned cntr_w, input int unsigned sec_w);
    return cntr_w + sec_w;
  endfunction

  // Dropped flag sits directly above the synthetic flag.
  function automatic int unsigned drop_bit(input int unsigned cntr_w, input int unsigned sec_w);
    return cntr_w + sec_w + 1;
  endfunction

  // tdata must hold cycles, seconds and both flag bits.
  function automatic bit tdata_width_ok(input int unsigned tdata_w, input int unsigned cntr_w,
                                        input int unsigned sec_w);
    return tdata_w >= (cntr_w + sec_w + 2);
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } pps_state_t;

endpackage

// File: rtl/pps_edge_sync.sv
// 3-stage synchroniser for an asynchronous PPS pin with a rising-edge pulse.
// Ports:
//   aclk, aresetn  clock and synchronous active-low reset
//   i_pps          asynchronous PPS input
//   o_rise_c       one-cycle pulse when the synchronised PPS rises (combinational from stages)
module pps_edge_sync (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_pps,
  output logic o_rise_c
);

  logic [2:0] r_sync;

  // Stage 0 absorbs metastability; stages 1 and 2 form the edge detector.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_pps};
    end
  end

  assign o_rise_c = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/axis_pps_timer.sv
// Timestamps a 1PPS input against aclk and emits one AXI-Stream word per tick:
// {zero pad, dropped, synthetic, seconds, cycles}.
// Ports:
//   aclk, aresetn   clock and synchronous active-low reset
//   pps_data        asynchronous PPS input
//   cfg_min         minimum accepted period in cycles (0 disables glitch rejection)
//   cfg_timeout     holdover period in cycles (0 disables synthetic ticks)
//   m_axis_*        single-entry registered AXI-Stream master
//   sts_locked      armed and the last tick came from a real PPS edge
module axis_pps_timer
  import axis_pps_timer_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 64,
  parameter int unsigned CNTR_WIDTH       = 30,
  parameter int unsigned SEC_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        pps_data,
  input  logic [CNTR_WIDTH-1:0]       cfg_min,
  input  logic [CNTR_WIDTH-1:0]       cfg_timeout,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        sts_locked
);

  localparam int unsigned SEC_LSB  = sec_lsb(CNTR_WIDTH);
  localparam int unsigned SYN_BIT  = syn_bit(CNTR_WIDTH, SEC_WIDTH);
  localparam int unsigned DROP_BIT = drop_bit(CNTR_WIDTH, SEC_WIDTH);

  if (!tdata_width_ok(AXIS_TDATA_WIDTH, CNTR_WIDTH, SEC_WIDTH)) begin : g_width_check
    $error("axis_pps_timer: AXIS_TDATA_WIDTH too small for CNTR_WIDTH+SEC_WIDTH+2");
  end

  pps_state_t                  r_state;
  pps_state_t                  w_state_nxt;
  logic                        w_edge;
  logic                        w_arm;
  logic                        w_real;
  logic                        w_syn;
  logic                        w_tick;
  logic                        w_load;
  logic [CNTR_WIDTH-1:0]       r_cnt;
  logic [CNTR_WIDTH-1:0]       w_period;
  logic [SEC_WIDTH-1:0]        r_sec;
  logic [SEC_WIDTH-1:0]        w_sec_nxt;
  logic                        r_dropped;
  logic                        r_locked;
  logic                        r_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
  logic [AXIS_TDATA_WIDTH-1:0] w_word;

  pps_edge_sync u_edge_sync (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_pps    (pps_data),
    .o_rise_c (w_edge)
  );

  // Period of the current second, saturating with the counter.
  assign w_period  = (r_cnt == '1) ? r_cnt : r_cnt + CNTR_WIDTH'(1);
  assign w_sec_nxt = r_sec + SEC_WIDTH'(1);
  assign w_tick    = w_real | w_syn;
  // The output register accepts a new word when empty or draining this cycle.
  assign w_load    = w_tick & (~r_tvalid | m_axis_tready);

  // Arming state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arming and tick classification; a real edge always wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_real      = 1'b0;
    w_syn       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_state_nxt = ST_ARMED;
          w_arm       = 1'b1;
        end
      end
      ST_ARMED: begin
        w_real = w_edge & ((cfg_min == '0) | (w_period >= cfg_min));
        w_syn  = ~w_real & (cfg_timeout != '0) & (w_period == cfg_timeout);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-second cycle counter; rejected edges leave it running.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (w_arm || w_tick) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNTR_WIDTH'(1);
    end
  end

  // Seconds and lock status advance on every tick, even when the word is dropped.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sec    <= '0;
      r_locked <= 1'b0;
    end else if (w_arm) begin
      r_sec    <= '0;
      r_locked <= 1'b0;
    end else if (w_tick) begin
      r_sec    <= w_sec_nxt;
      r_locked <= ~w_syn;
    end
  end

  // Assemble the outgoing word; pad bits stay zero.
  always_comb begin
    w_word                          = '0;
    w_word[CYC_LSB +: CNTR_WIDTH]   = w_period;
    w_word[SEC_LSB +: SEC_WIDTH]    = w_sec_nxt;
    w_word[SYN_BIT]                 = w_syn;
    w_word[DROP_BIT]                = r_dropped;
  end

  // Single-entry output register with sticky drop flag; loading a word reports and clears it.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_dropped <= 1'b0;
    end else if (w_load) begin
      r_tvalid  <= 1'b1;
      r_tdata   <= w_word;
      r_dropped <= 1'b0;
    end else begin
      if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
      if (w_tick) begin
        r_dropped <= 1'b1;
      end
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign sts_locked    = r_locked;

endmodule

// File: tb/tb_axis_pps_timer.sv
// Directed bench for axis_pps_timer with a scoreboard of expected output words.
module tb_axis_pps_timer;

  localparam int unsigned TW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          pps_data;
  logic [CW-1:0] cfg_min;
  logic [CW-1:0] cfg_timeout;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          sts_locked;

  int            n_checks = 0;
  int            n_err    = 0;
  logic [TW-1:0] exp_q[$];

  axis_pps_timer #(
    .AXIS_TDATA_WIDTH (TW),
    .CNTR_WIDTH       (CW),
    .SEC_WIDTH        (SW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .pps_data      (pps_data),
    .cfg_min       (cfg_min),
    .cfg_timeout   (cfg_timeout),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_locked    (sts_locked)
  );

  always #5 aclk = ~aclk;

  // Expected word: cycles[15:0], seconds[19:16], synthetic[20], dropped[21], pad zero.
  function automatic logic [TW-1:0] mkword(input logic drop, input logic syn,
                                           input int sec, input int cyc);
    logic [TW-1:0] w;
    w        = '0;
    w[15:0]  = 16'(cyc);
    w[19:16] = 4'(sec);
    w[20]    = syn;
    w[21]    = drop;
    return w;
  endfunction

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // PPS pulse two cycles high, then low for the rest of a period of p cycles.
  task automatic pps_period(input int p);
    pps_data = 1'b1;
    wait_clk(2);
    pps_data = 1'b0;
    wait_clk(p - 2);
  endtask

  // Scoreboard: every accepted word must match the oldest expectation.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(exp_q.size()), 32'd1);
      end else begin
        check("word", m_axis_tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    aresetn       = 1'b0;
    pps_data      = 1'b0;
    cfg_min       = '0;
    cfg_timeout   = '0;
    m_axis_tready = 1'b1;
    wait_clk(3);
    check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("reset_tdata", m_axis_tdata, 32'd0);
    check("reset_locked", 32'(sts_locked), 32'd0);
    aresetn = 1'b1;
    wait_clk(2);

    // Period 10: first edge only arms, then seconds 1..3.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) exp_q.push_back(mkword(1'b0, 1'b0, i, 10));
      pps_period(10);
    end
    check("p1_locked", 32'(sts_locked), 32'd1);
    check("p1_tvalid_pulse", 32'(m_axis_tvalid), 32'd0);

    // Glitch 4 cycles after a tick is rejected; next word still sees 10 cycles.
    cfg_min = 16'd8;
    exp_q.push_back(mkword(1'b0, 1'b0, 4, 10));
    pps_data = 1'b1;
    wait_clk(2);
    pps_data = 1'b0;
    wait_clk(2);
    pps_data = 1'b1;
    wait_clk(1);
    pps_data = 1'b0;
    wait_clk(5);
    exp_q.push_back(mkword(1'b0, 1'b0, 5, 10));
    pps_period(10);

    // Holdover: two real ticks, PPS stops, synthetic ticks every 12 cycles, then PPS resumes.
    cfg_timeout = 16'd12;
    exp_q.push_back(mkword(1'b0, 1'b0, 6, 10));
    pps_period(10);
    exp_q.push_back(mkword(1'b0, 1'b0, 7, 10));
    exp_q.push_back(mkword(1'b0, 1'b1, 8, 12));
    exp_q.push_back(mkword(1'b0, 1'b1, 9, 12));
    exp_q.push_back(mkword(1'b0, 1'b1, 10, 12));
    pps_period(40);
    check("holdover_locked", 32'(sts_locked), 32'd0);
    wait_clk(6);
    exp_q.push_back(mkword(1'b0, 1'b0, 11, 10));
    pps_period(10);
    check("resume_locked", 32'(sts_locked), 32'd1);

    // Backpressure: hold first word, drop two ticks, then flag the drop; seconds wrap 15->0->1.
    cfg_timeout   = '0;
    m_axis_tready = 1'b0;
    exp_q.push_back(mkword(1'b0, 1'b0, 12, 10));
    pps_period(10);
    pps_period(10);
    pps_period(10);
    check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("hold_tdata", m_axis_tdata, mkword(1'b0, 1'b0, 12, 10));
    m_axis_tready = 1'b1;
    exp_q.push_back(mkword(1'b1, 1'b0, 15, 10));
    pps_period(10);
    exp_q.push_back(mkword(1'b0, 1'b0, 0, 10));
    pps_period(10);
    exp_q.push_back(mkword(1'b0, 1'b0, 1, 10));
    pps_period(10);

    // Reset while a word is pending aborts it; re-arm takes one edge, word on the second.
    m_axis_tready = 1'b0;
    pps_data = 1'b1;
    wait_clk(2);
    pps_data = 1'b0;
    wait_clk(3);
    check("pending_tvalid", 32'(m_axis_tvalid), 32'd1);
    aresetn = 1'b0;
    wait_clk(1);
    aresetn = 1'b1;
    check("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_mid_tdata", m_axis_tdata, 32'd0);
    check("rst_mid_locked", 32'(sts_locked), 32'd0);
    m_axis_tready = 1'b1;
    pps_period(10);
    check("rearm_no_word", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(mkword(1'b0, 1'b0, 1, 10));
    pps_period(10);
    check("rearm_locked", 32'(sts_locked), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
